// File: rtl/i2s_rx_dsp_sched.sv
// Round-robin merge of two I2S DSP-mode RX word streams into the uDMA RX FIFO port.
// Sequences capture sessions (enable, word limit, drain, done) and flags starved sources.
module i2s_rx_dsp_sched #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_en_i,
  input  logic              cfg_continuous_i,
  input  logic [CNT_W-1:0]  cfg_num_words_i,
  input  logic [1:0]        cfg_ch_mask_i,
  input  logic [DATA_W-1:0] src0_data_i,
  input  logic              src0_valid_i,
  output logic              src0_ready_o,
  input  logic [DATA_W-1:0] src1_data_i,
  input  logic              src1_valid_i,
  output logic              src1_ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              ch_id_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [4:0] WAIT_LIM = 5'(WAIT_MAX);

  state_t             state_q, state_d;
  logic               last_q;
  logic [DATA_W-1:0]  data_q;
  logic               ch_q;
  logic               valid_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic               done_q;
  logic [1:0]         err_q;
  logic               limit_q;
  logic [3:0]         stv_q [2];

  logic [1:0]         cand;
  logic [1:0]         gnt;
  logic               slot_free;
  logic               lim_now;
  logic               hit_limit;
  logic               can_grant;
  logic [CNT_W:0]     cnt_p1;
  logic [CNT_W-1:0]   cnt_inc;
  logic               start;

  assign cand      = {src1_valid_i & cfg_ch_mask_i[1], src0_valid_i & cfg_ch_mask_i[0]};
  assign slot_free = ~valid_q | ready_i;
  assign lim_now   = ~cfg_continuous_i & (word_cnt_q >= cfg_num_words_i);
  assign cnt_p1    = {1'b0, word_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign hit_limit = ~cfg_continuous_i & (cnt_p1 >= {1'b0, cfg_num_words_i});
  assign cnt_inc   = (&word_cnt_q) ? word_cnt_q : cnt_p1[CNT_W-1:0];
  assign can_grant = (state_q == RUN) & cfg_en_i & ~lim_now & slot_free;
  assign start     = (state_q == IDLE) & cfg_en_i;

  // Tie goes to the source that was not served last
  assign gnt[0] = can_grant & cand[0] & (~cand[1] | last_q);
  assign gnt[1] = can_grant & cand[1] & (~cand[0] | ~last_q);

  always_comb begin
    state_d      = state_q;
    src0_ready_o = 1'b0;
    src1_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_en_i)
          state_d = (~cfg_continuous_i && cfg_num_words_i == '0) ? DONE : RUN;
      end
      RUN: begin
        src0_ready_o = ~cfg_ch_mask_i[0] | gnt[0];
        src1_ready_o = ~cfg_ch_mask_i[1] | gnt[1];
        if (!cfg_en_i || lim_now || ((|gnt) && hit_limit))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!valid_q)
          state_d = limit_q ? DONE : IDLE;
      end
      DONE: begin
        if (!cfg_en_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      data_q     <= '0;
      ch_q       <= 1'b0;
      valid_q    <= 1'b0;
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= '0;
      limit_q    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) stv_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE) && (state_q != DONE);

      if (start) begin
        word_cnt_q <= '0;
        err_q      <= '0;
        last_q     <= 1'b1;
        limit_q    <= 1'b0;
        for (int unsigned i = 0; i < 2; i++) stv_q[i] <= '0;
      end else begin
        if (|gnt) begin
          data_q     <= gnt[1] ? src1_data_i : src0_data_i;
          ch_q       <= gnt[1];
          last_q     <= gnt[1];
          valid_q    <= 1'b1;
          word_cnt_q <= cnt_inc;
        end else if (valid_q && ready_i) begin
          valid_q <= 1'b0;
        end

        if (state_q == RUN && cfg_en_i && (lim_now || ((|gnt) && hit_limit)))
          limit_q <= 1'b1;

        if (state_q == RUN) begin
          for (int unsigned i = 0; i < 2; i++) begin
            if (gnt[i] || !cand[i]) begin
              stv_q[i] <= '0;
            end else begin
              if (stv_q[i] != 4'hF) stv_q[i] <= stv_q[i] + 4'd1;
              if (({1'b0, stv_q[i]} + 5'd1) >= WAIT_LIM) err_q[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign data_o     = data_q;
  assign ch_id_o    = ch_q;
  assign valid_o    = valid_q;
  assign word_cnt_o = word_cnt_q;
  assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_i2s_rx_dsp_sched.sv
// Directed bench for i2s_rx_dsp_sched: session sequencing, arbitration, backpressure,
// masking, starvation flags and asynchronous reset.
module tb_i2s_rx_dsp_sched;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [31:0] D0 = 32'h1111_00A0;
  localparam logic [31:0] D1 = 32'h2222_00B1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cfg_en_i;
  logic              cfg_continuous_i;
  logic [CNT_W-1:0]  cfg_num_words_i;
  logic [1:0]        cfg_ch_mask_i;
  logic [DATA_W-1:0] src0_data_i;
  logic              src0_valid_i;
  logic              src0_ready_o;
  logic [DATA_W-1:0] src1_data_i;
  logic              src1_valid_i;
  logic              src1_ready_o;
  logic [DATA_W-1:0] data_o;
  logic              ch_id_o;
  logic              valid_o;
  logic              ready_i;
  logic [CNT_W-1:0]  word_cnt_o;
  logic              busy_o;
  logic              done_o;
  logic [1:0]        err_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  i2s_rx_dsp_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .WAIT_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_en_i(cfg_en_i), .cfg_continuous_i(cfg_continuous_i),
    .cfg_num_words_i(cfg_num_words_i), .cfg_ch_mask_i(cfg_ch_mask_i),
    .src0_data_i(src0_data_i), .src0_valid_i(src0_valid_i), .src0_ready_o(src0_ready_o),
    .src1_data_i(src1_data_i), .src1_valid_i(src1_valid_i), .src1_ready_o(src1_ready_o),
    .data_o(data_o), .ch_id_o(ch_id_o), .valid_o(valid_o), .ready_i(ready_i),
    .word_cnt_o(word_cnt_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic ch, input logic [31:0] cnt);
    check({tag, "_valid"}, 32'(valid_o), 32'd1);
    check({tag, "_ch"}, 32'(ch_id_o), 32'(ch));
    check({tag, "_data"}, data_o, ch ? D1 : D0);
    check({tag, "_cnt"}, 32'(word_cnt_o), cnt);
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 1'b0; cfg_continuous_i = 1'b0; cfg_num_words_i = '0;
    cfg_ch_mask_i = 2'b00; src0_data_i = D0; src0_valid_i = 1'b0;
    src1_data_i = D1; src1_valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_cnt", 32'(word_cnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // Limited session of 4 words, both sources always valid
    cfg_num_words_i = 16'd4; cfg_ch_mask_i = 2'b11;
    src0_valid_i = 1'b1; src1_valid_i = 1'b1; ready_i = 1'b1; cfg_en_i = 1'b1;
    #1;
    check("idle_rdy0", 32'(src0_ready_o), 32'd0);
    check("idle_rdy1", 32'(src1_ready_o), 32'd0);
    tick();
    check("t1_busy", 32'(busy_o), 32'd1);
    check("t1_gnt0", 32'(src0_ready_o), 32'd1);
    check("t1_nognt1", 32'(src1_ready_o), 32'd0);
    tick(); chk_word("t1_w0", 1'b0, 32'd1);
    check("t1_gnt1", 32'(src1_ready_o), 32'd1);
    tick(); chk_word("t1_w1", 1'b1, 32'd2);
    tick(); chk_word("t1_w2", 1'b0, 32'd3);
    tick(); chk_word("t1_w3", 1'b1, 32'd4);
    check("t1_drain_rdy0", 32'(src0_ready_o), 32'd0);
    check("t1_drain_busy", 32'(busy_o), 32'd1);
    tick();
    check("t1_empty", 32'(valid_o), 32'd0);
    check("t1_nodone", 32'(done_o), 32'd0);
    tick();
    check("t1_done", 32'(done_o), 32'd1);
    check("t1_idlebusy", 32'(busy_o), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done_o), 32'd0);
    cfg_en_i = 1'b0;
    tick();

    // Continuous session: backpressure with starvation, then disable while stalled
    cfg_continuous_i = 1'b1; cfg_en_i = 1'b1;
    tick();
    check("t2_cnt_clr", 32'(word_cnt_o), 32'd0);
    tick(); chk_word("t2_w0", 1'b0, 32'd1);
    ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check("bp_rdy0", 32'(src0_ready_o), 32'd0);
      check("bp_rdy1", 32'(src1_ready_o), 32'd0);
      tick();
      chk_word("bp_hold", 1'b0, 32'd1);
      check("bp_err", 32'(err_o), (k < 3) ? 32'd0 : (k == 3) ? 32'd2 : 32'd3);
    end
    ready_i = 1'b1;
    #1;
    check("rel_gnt1", 32'(src1_ready_o), 32'd1);
    check("rel_nognt0", 32'(src0_ready_o), 32'd0);
    tick(); chk_word("rel_w1", 1'b1, 32'd2);
    ready_i = 1'b0; cfg_en_i = 1'b0;
    #1;
    check("dis_rdy0", 32'(src0_ready_o), 32'd0);
    check("dis_rdy1", 32'(src1_ready_o), 32'd0);
    tick();
    chk_word("drain_hold", 1'b1, 32'd2);
    check("drain_busy", 32'(busy_o), 32'd1);
    ready_i = 1'b1;
    tick();
    check("drain_empty", 32'(valid_o), 32'd0);
    check("drain_nodone", 32'(done_o), 32'd0);
    tick();
    check("t4_idle", 32'(busy_o), 32'd0);
    check("t4_nodone", 32'(done_o), 32'd0);
    check("t4_err_sticky", 32'(err_o), 32'd3);

    // Re-enable with source 1 masked; err clears on the IDLE-to-RUN step
    cfg_ch_mask_i = 2'b01; cfg_continuous_i = 1'b0; cfg_num_words_i = 16'd3; cfg_en_i = 1'b1;
    #1;
    check("t3_err_pre", 32'(err_o), 32'd3);
    tick();
    check("t3_err_clr", 32'(err_o), 32'd0);
    check("t3_gnt0", 32'(src0_ready_o), 32'd1);
    check("t3_mask_rdy1", 32'(src1_ready_o), 32'd1);
    tick(); chk_word("t3_w0", 1'b0, 32'd1);
    tick(); chk_word("t3_w1", 1'b0, 32'd2);
    check("t3_mask_rdy1b", 32'(src1_ready_o), 32'd1);
    tick(); chk_word("t3_w2", 1'b0, 32'd3);
    tick();
    check("t3_empty", 32'(valid_o), 32'd0);
    tick();
    check("t3_done", 32'(done_o), 32'd1);
    check("t3_err", 32'(err_o), 32'd0);
    check("t3_cnt", 32'(word_cnt_o), 32'd3);
    cfg_en_i = 1'b0;
    tick();

    // Zero-length session goes straight to DONE
    cfg_ch_mask_i = 2'b11; cfg_num_words_i = '0; cfg_en_i = 1'b1;
    #1;
    check("z_rdy0", 32'(src0_ready_o), 32'd0);
    check("z_rdy1", 32'(src1_ready_o), 32'd0);
    tick();
    check("z_done", 32'(done_o), 32'd1);
    check("z_busy", 32'(busy_o), 32'd0);
    check("z_valid", 32'(valid_o), 32'd0);
    check("z_cnt", 32'(word_cnt_o), 32'd0);
    check("z_rdy0b", 32'(src0_ready_o), 32'd0);
    tick();
    check("z_done_pulse", 32'(done_o), 32'd0);
    cfg_en_i = 1'b0;
    tick();

    // Asynchronous reset mid-RUN
    cfg_continuous_i = 1'b1; cfg_en_i = 1'b1;
    tick();
    tick(); chk_word("ar_w0", 1'b0, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("ar_valid", 32'(valid_o), 32'd0);
    check("ar_data", data_o, 32'd0);
    check("ar_cnt", 32'(word_cnt_o), 32'd0);
    check("ar_busy", 32'(busy_o), 32'd0);
    check("ar_rdy0", 32'(src0_ready_o), 32'd0);
    check("ar_rdy1", 32'(src1_ready_o), 32'd0);
    check("ar_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
